// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared types for the up/down sweep sequencer: sweep modes and FSM states.
package updown_sweep_pkg;

    localparam logic [1:0] MODE_ONE_UP    = 2'd0;
    localparam logic [1:0] MODE_ONE_DOWN  = 2'd1;
    localparam logic [1:0] MODE_PINGPONG  = 2'd2;
    localparam logic [1:0] MODE_REPEAT_UP = 2'd3;

    typedef enum logic [1:0] {
        ONE_UP    = MODE_ONE_UP,
        ONE_DOWN  = MODE_ONE_DOWN,
        PINGPONG  = MODE_PINGPONG,
        REPEAT_UP = MODE_REPEAT_UP
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/updown_sweep_ctrl_counter.sv
// Bounded up/down counter datapath. Load wins over enable; the controller
// owns every wrap/turn decision, this block only moves by one and flags bounds.
module bounded_updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir_up,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] count,
    output logic             at_lo,
    output logic             at_hi
);

    // count register: load, else single step in the requested direction
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= dir_up ? count + 1'b1 : count - 1'b1;
    end

    assign at_lo = (count == lo);
    assign at_hi = (count == hi);

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer: walks a bounded counter between programmed lo/hi bounds in
// one-shot up/down, ping-pong or repeat-up mode, with start/done handshake.
// Optional macro UPDOWN_SWEEP_BOUND_IRQ_EN adds a registered bound_hit pulse.
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              step_en,
    input  logic [WIDTH-1:0]  cfg_lo,
    input  logic [WIDTH-1:0]  cfg_hi,
    input  logic [1:0]        cfg_mode,
    input  logic [PASS_W-1:0] cfg_passes,
    output logic [WIDTH-1:0]  count,
    output logic              dir_up,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
`ifdef UPDOWN_SWEEP_BOUND_IRQ_EN
    output logic              bound_hit,
`endif
    output logic [PASS_W-1:0] pass_cnt
);

    state_e            state;
    mode_e             mode_q;
    logic [WIDTH-1:0]  lo_q, hi_q;
    logic [PASS_W-1:0] passes_q;

    logic              at_lo, at_hi;
    logic              step;
    logic              cnt_ld, cnt_en, cnt_dir;
    logic [WIDTH-1:0]  cnt_ld_val;
    logic              fin, dir_nxt, pass_inc, evt;
    logic [PASS_W-1:0] pass_nxt;
    logic              pass_goal;

    bounded_updown_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_ld),
        .load_val (cnt_ld_val),
        .en       (cnt_en),
        .dir_up   (cnt_dir),
        .lo       (lo_q),
        .hi       (hi_q),
        .count    (count),
        .at_lo    (at_lo),
        .at_hi    (at_hi)
    );

    assign step      = (state == RUN) && step_en && !abort;
    // pass count sticks at all-ones for endless sweeps
    assign pass_nxt  = (&pass_cnt) ? pass_cnt : pass_cnt + 1'b1;
    assign pass_goal = (passes_q != '0) && (pass_nxt == passes_q);

    // per-step decision: counter move, turn, pass increment and completion
    always_comb begin
        cnt_ld     = 1'b0;
        cnt_ld_val = lo_q;
        cnt_en     = 1'b0;
        cnt_dir    = dir_up;
        fin        = 1'b0;
        dir_nxt    = dir_up;
        pass_inc   = 1'b0;
        evt        = 1'b0;
        if (state == IDLE && start && cfg_lo <= cfg_hi) begin
            cnt_ld     = 1'b1;
            cnt_ld_val = (mode_e'(cfg_mode) == ONE_DOWN) ? cfg_hi : cfg_lo;
        end else if (step) begin
            case (mode_q)
                ONE_UP: begin
                    if (at_hi) begin fin = 1'b1; evt = 1'b1; end
                    else       begin cnt_en = 1'b1; cnt_dir = 1'b1; end
                end
                ONE_DOWN: begin
                    if (at_lo) begin fin = 1'b1; evt = 1'b1; end
                    else       begin cnt_en = 1'b1; cnt_dir = 1'b0; end
                end
                REPEAT_UP: begin
                    if (at_hi) begin
                        cnt_ld   = 1'b1;
                        pass_inc = 1'b1;
                        evt      = 1'b1;
                        fin      = pass_goal;
                    end else begin
                        cnt_en = 1'b1; cnt_dir = 1'b1;
                    end
                end
                PINGPONG: begin
                    if (dir_up) begin
                        if (at_hi) begin
                            // turn down; with lo==hi the count stays put
                            dir_nxt = 1'b0;
                            evt     = 1'b1;
                            cnt_en  = !at_lo;
                            cnt_dir = 1'b0;
                        end else begin
                            cnt_en = 1'b1; cnt_dir = 1'b1;
                        end
                    end else begin
                        if (at_lo) begin
                            // a full lo->hi->lo trip ends here
                            pass_inc = 1'b1;
                            evt      = 1'b1;
                            if (pass_goal) begin
                                fin = 1'b1;
                            end else begin
                                dir_nxt = 1'b1;
                                cnt_en  = !at_hi;
                                cnt_dir = 1'b1;
                            end
                        end else begin
                            cnt_en = 1'b1; cnt_dir = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // sweep FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mode_q   <= ONE_UP;
            lo_q     <= '0;
            hi_q     <= '0;
            passes_q <= '0;
            dir_up   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            pass_cnt <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_lo > cfg_hi) begin
                            cfg_err <= 1'b1;
                        end else begin
                            mode_q   <= mode_e'(cfg_mode);
                            lo_q     <= cfg_lo;
                            hi_q     <= cfg_hi;
                            passes_q <= cfg_passes;
                            pass_cnt <= '0;
                            dir_up   <= (mode_e'(cfg_mode) != ONE_DOWN);
                            busy     <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (step) begin
                        dir_up <= dir_nxt;
                        if (pass_inc)
                            pass_cnt <= pass_nxt;
                        if (fin) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UPDOWN_SWEEP_BOUND_IRQ_EN
    logic [WIDTH-1:0] nxt_val;
    logic             hit;

    assign nxt_val = cnt_dir ? count + 1'b1 : count - 1'b1;
    assign hit     = step && (evt || (cnt_en && (nxt_val == lo_q || nxt_val == hi_q)));

    // one-cycle pulse after any step that lands on or turns at a bound
    always_ff @(posedge clk) begin
        if (reset)
            bound_hit <= 1'b0;
        else
            bound_hit <= hit;
    end
`endif

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl: directed scenarios plus random
// sweeps compared against a precomputed list of expected per-step results.
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, abort, step_en;
    logic [3:0] cfg_lo, cfg_hi;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_passes;
    logic [3:0] count;
    logic       dir_up, busy, done, cfg_err;
    logic [7:0] pass_cnt;
`ifdef UPDOWN_SWEEP_BOUND_IRQ_EN
    logic       bound_hit;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int cnt;
        int pc;
        bit hit;
    } step_t;

    updown_sweep_ctrl #(.WIDTH(4), .PASS_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .step_en    (step_en),
        .cfg_lo     (cfg_lo),
        .cfg_hi     (cfg_hi),
        .cfg_mode   (cfg_mode),
        .cfg_passes (cfg_passes),
        .count      (count),
        .dir_up     (dir_up),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
`ifdef UPDOWN_SWEEP_BOUND_IRQ_EN
        .bound_hit  (bound_hit),
`endif
        .pass_cnt   (pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int lo, input int hi, input int mode, input int passes);
        cfg_lo     = lo[3:0];
        cfg_hi     = hi[3:0];
        cfg_mode   = mode[1:0];
        cfg_passes = passes[7:0];
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; step_en = 1'b0;
        cfg_lo = '0; cfg_hi = '0; cfg_mode = '0; cfg_passes = '0;
        tick(); tick();
        reset = 1'b0;
        n_chk++;
        if (count !== 4'd0 || dir_up !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            cfg_err !== 1'b0 || pass_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d dir=%b busy=%b done=%b err=%b pass=%0d, want 0/1/0/0/0/0",
                     count, dir_up, busy, done, cfg_err, pass_cnt);
        end
        // reach count=9 mid-sweep, then reset with a step also requested
        do_start(8, 12, 0, 0);
        step_en = 1'b1;
        tick();
        n_chk++;
        if (count !== 4'd9 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre: count=%0d busy=%b, want 9/1", count, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; step_en = 1'b0;
        n_chk++;
        if (count !== 4'd0 || busy !== 1'b0 || dir_up !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midsweep: count=%0d busy=%b dir=%b done=%b, want 0/0/1/0",
                     count, busy, dir_up, done);
        end
    endtask

    task automatic test_one_up();
        int busy_cycles = 0;
        int done_cnt = 0;
        int done_at = -1;
        do_start(3, 6, 0, 0);
        step_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) begin
                n_chk++;
                if (count !== 4'(3 + busy_cycles)) begin
                    n_fail++;
                    $display("FAIL one_up_count: cycle %0d count=%0d, want %0d", i, count, 3 + busy_cycles);
                end
                busy_cycles++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_at = i;
                n_chk++;
                if (count !== 4'd6) begin
                    n_fail++;
                    $display("FAIL one_up_hold: count=%0d at done, want 6", count);
                end
            end
            tick();
        end
        step_en = 1'b0;
        n_chk++;
        if (busy_cycles != 4 || done_cnt != 1 || done_at != 4) begin
            n_fail++;
            $display("FAIL one_up_timing: busy_cycles=%0d done_cnt=%0d done_at=%0d, want 4/1/4",
                     busy_cycles, done_cnt, done_at);
        end
    endtask

    task automatic test_pingpong();
        int exp_seq[9] = '{2, 3, 4, 3, 2, 3, 4, 3, 2};
        do_start(2, 4, 2, 2);
        step_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            n_chk++;
            if (count !== 4'(exp_seq[i]) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL pingpong_seq: step %0d count=%0d done=%b, want %0d/0", i, count, done, exp_seq[i]);
            end
            tick();
        end
        step_en = 1'b0;
        n_chk++;
        if (done !== 1'b1 || pass_cnt !== 8'd2 || dir_up !== 1'b0 || count !== 4'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pingpong_end: done=%b pass=%0d dir=%b count=%0d busy=%b, want 1/2/0/2/0",
                     done, pass_cnt, dir_up, count, busy);
        end
        tick();
        n_chk++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL pingpong_done_width: done=%b, want 0", done);
        end
    endtask

    task automatic test_repeat_abort();
        int e = 14;
        do_start(14, 15, 3, 0);
        for (int i = 0; i < 10; i++) begin
            step_en = (i % 2 == 0);
            tick();
            if (i % 2 == 0) e = (e == 15) ? 14 : e + 1;
            n_chk++;
            if (count !== 4'(e) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL repeat_count: cycle %0d count=%0d busy=%b, want %0d/1", i, count, busy, e);
            end
        end
        n_chk++;
        if (pass_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL repeat_passes: pass=%0d, want 2", pass_cnt);
        end
        abort = 1'b1; step_en = 1'b1;
        tick();
        abort = 1'b0; step_en = 1'b0;
        n_chk++;
        if (count !== 4'(e) || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: count=%0d busy=%b done=%b, want %0d/0/0", count, busy, done, e);
        end
        tick();
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_after: done=%b busy=%b, want 0/0", done, busy);
        end
    endtask

    task automatic test_cfg_err();
        logic [3:0] c0;
        c0 = count;
        do_start(9, 5, 0, 0);
        n_chk++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || count !== c0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_pulse: err=%b busy=%b count=%0d done=%b, want 1/0/%0d/0",
                     cfg_err, busy, count, done, c0);
        end
        tick();
        n_chk++;
        if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_width: err=%b busy=%b, want 0/0", cfg_err, busy);
        end
    endtask

    task automatic test_degenerate();
        do_start(7, 7, 1, 0);
        n_chk++;
        if (count !== 4'd7 || dir_up !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL degen_start: count=%0d dir=%b busy=%b, want 7/0/1", count, dir_up, busy);
        end
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
        n_chk++;
        if (done !== 1'b1 || count !== 4'd7 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL degen_done: done=%b count=%0d busy=%b, want 1/7/0", done, count, busy);
        end
`ifdef UPDOWN_SWEEP_BOUND_IRQ_EN
        n_chk++;
        if (bound_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL degen_bound_hit: got %b, want 1", bound_hit);
        end
`endif
        tick();
        n_chk++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL degen_done_width: done=%b, want 0", done);
        end
`ifdef UPDOWN_SWEEP_BOUND_IRQ_EN
        n_chk++;
        if (bound_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL degen_bound_width: got %b, want 0", bound_hit);
        end
`endif
    endtask

    task automatic test_saturate();
        do_start(5, 5, 3, 0);
        step_en = 1'b1;
        repeat (300) tick();
        step_en = 1'b0;
        n_chk++;
        if (pass_cnt !== 8'd255 || busy !== 1'b1 || count !== 4'd5) begin
            n_fail++;
            $display("FAIL saturate: pass=%0d busy=%b count=%0d, want 255/1/5", pass_cnt, busy, count);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL saturate_abort: busy=%b done=%b, want 0/0", busy, done);
        end
    endtask

    // expected counter value, pass count and bound flag after each accepted step
    task automatic build_sweep(input int lo, input int hi, input int mode, input int passes,
                               output step_t q[$]);
        int pc = 0;
        bit first = 1'b1;
        q = {};
        case (mode)
            0: begin
                for (int v = lo + 1; v <= hi; v++) q.push_back('{v, 0, v == hi});
                q.push_back('{hi, 0, 1'b1});
            end
            1: begin
                for (int v = hi - 1; v >= lo; v--) q.push_back('{v, 0, v == lo});
                q.push_back('{lo, 0, 1'b1});
            end
            3: begin
                for (int p = 0; p < passes; p++) begin
                    for (int v = lo + 1; v <= hi; v++) q.push_back('{v, pc, v == hi});
                    pc++;
                    q.push_back('{lo, pc, 1'b1});
                end
            end
            default: begin
                if (lo == hi) begin
                    for (int p = 0; p < passes; p++) begin
                        q.push_back('{lo, pc, 1'b1});
                        pc++;
                        q.push_back('{lo, pc, 1'b1});
                    end
                end else begin
                    for (int p = 0; p < passes; p++) begin
                        for (int v = lo + 1; v <= hi; v++)
                            q.push_back('{v, pc, (v == hi) || (v == lo + 1 && !first)});
                        first = 1'b0;
                        for (int v = hi - 1; v >= lo; v--)
                            q.push_back('{v, pc, (v == lo) || (v == hi - 1)});
                        pc++;
                    end
                    q.push_back('{lo, pc, 1'b1});
                end
            end
        endcase
    endtask

    task automatic test_random();
        step_t q[$];
        step_t e;
        int lo, hi, mode, passes, last, guard;
        bit stepped;
        for (int s = 0; s < 40; s++) begin
            lo     = $urandom_range(0, 15);
            hi     = $urandom_range(lo, 15);
            mode   = $urandom_range(0, 3);
            passes = $urandom_range(1, 3);
            build_sweep(lo, hi, mode, passes, q);
            do_start(lo, hi, mode, passes);
            last = (mode == 1) ? hi : lo;
            n_chk++;
            if (count !== 4'(last) || busy !== 1'b1 || pass_cnt !== 8'd0 || dir_up !== (mode != 1)) begin
                n_fail++;
                $display("FAIL rand_start: sweep %0d mode %0d count=%0d busy=%b pass=%0d dir=%b, want %0d/1/0/%b",
                         s, mode, count, busy, pass_cnt, dir_up, last, mode != 1);
            end
            guard = 0;
            while (q.size() != 0) begin
                // scramble config and pulse start: both must be ignored while running
                step_en    = $urandom_range(0, 1);
                start      = $urandom_range(0, 1);
                cfg_lo     = 4'($urandom_range(0, 15));
                cfg_hi     = 4'($urandom_range(0, 15));
                cfg_mode   = 2'($urandom_range(0, 3));
                cfg_passes = 8'($urandom_range(0, 255));
                stepped    = step_en;
                tick();
                guard++;
                if (stepped) begin
                    e = q.pop_front();
                    last = e.cnt;
                    n_chk++;
                    if (count !== 4'(e.cnt) || pass_cnt !== 8'(e.pc) ||
                        done !== (q.size() == 0) || busy !== (q.size() != 0)) begin
                        n_fail++;
                        $display("FAIL rand_step: sweep %0d mode %0d lo %0d hi %0d count=%0d pass=%0d done=%b busy=%b, want %0d/%0d/%b/%b",
                                 s, mode, lo, hi, count, pass_cnt, done, busy, e.cnt, e.pc, q.size() == 0, q.size() != 0);
                    end
`ifdef UPDOWN_SWEEP_BOUND_IRQ_EN
                    n_chk++;
                    if (bound_hit !== e.hit) begin
                        n_fail++;
                        $display("FAIL rand_bound_hit: sweep %0d count=%0d got %b, want %b", s, count, bound_hit, e.hit);
                    end
`endif
                end else begin
                    n_chk++;
                    if (count !== 4'(last) || done !== 1'b0 || busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL rand_hold: sweep %0d count=%0d done=%b busy=%b, want %0d/0/1",
                                 s, count, done, busy, last);
                    end
                end
                if (guard > 2000) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rand_timeout: sweep %0d still has %0d steps pending", s, q.size());
                    q = {};
                end
            end
            start = 1'b0; step_en = 1'b0;
            n_chk++;
            if (dir_up !== (mode == 0 || mode == 3)) begin
                n_fail++;
                $display("FAIL rand_dir_end: sweep %0d mode %0d dir=%b, want %b", s, mode, dir_up, mode == 0 || mode == 3);
            end
            tick();
            n_chk++;
            if (done !== 1'b0 || busy !== 1'b0 || count !== 4'(last)) begin
                n_fail++;
                $display("FAIL rand_after: sweep %0d done=%b busy=%b count=%0d, want 0/0/%0d", s, done, busy, count, last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_up();
        test_pingpong();
        test_repeat_abort();
        test_cfg_err();
        test_degenerate();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
